// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 device-to-host frame receiver with Set-2 E0/F0 prefix folding.
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state, state_nx;
  logic          clk_d;
  logic          fall;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_pend, brk_pend;
  logic          timeout, frame_done, frame_good;

  assign fall       = clk_d & ~ps2_clk;
  // A real edge wins over a coincident timeout so a slow-but-live frame still completes.
  assign timeout    = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES));
  assign frame_done = (state == STOP) && fall;
  assign frame_good = ps2_data & (^shreg ^ par_bit);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!ps2_data) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_d   <= 1'b1;
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      clk_d <= ps2_clk;
      if (state == IDLE || fall)      to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:   bit_cnt <= 3'd0;
          DATA: begin
            shreg   <= {ps2_data, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= ps2_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      key_valid  <= 1'b0;
      frame_err  <= 1'b0;
      if (timeout || (frame_done && !frame_good)) begin
        frame_err <= 1'b1;
        ext_pend  <= 1'b0;
        brk_pend  <= 1'b0;
      end else if (frame_done) begin
        byte_valid <= 1'b1;
        byte_out   <= shreg;
        if (shreg == 8'hE0) begin
          ext_pend <= 1'b1;
        end else if (shreg == 8'hF0) begin
          brk_pend <= 1'b1;
        end else begin
          key_code  <= shreg;
          key_ext   <= ext_pend;
          key_break <= brk_pend;
          key_valid <= 1'b1;
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx.
module tb_ps2_scancode_rx;

  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk, ps2_data;
  logic [7:0] byte_out, key_code;
  logic       byte_valid, key_ext, key_break, key_valid, frame_err, busy;

  ps2_scancode_rx #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .key_valid(key_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_t;

  key_t       exp_key[$];
  logic [7:0] exp_byte[$];
  int         exp_err = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         stop_cyc = 0;
  logic       m_ext = 1'b0, m_brk = 1'b0;
  key_t       mk;
  logic [7:0] mb;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected events popped and compared as the DUT emits them.
  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        vectors++;
        if (exp_key.size() == 0) begin
          miscompares++;
          $display("FAIL key_unexpected: got code=%02h ext=%0b brk=%0b, expected no key event", key_code, key_ext, key_break);
        end else begin
          mk = exp_key.pop_front();
          if ({key_code, key_ext, key_break} !== {mk.code, mk.ext, mk.brk}) begin
            miscompares++;
            $display("FAIL key_event: got code=%02h ext=%0b brk=%0b, expected code=%02h ext=%0b brk=%0b",
                     key_code, key_ext, key_break, mk.code, mk.ext, mk.brk);
          end
        end
        vectors++;
        if (cyc - stop_cyc != 1 || frame_err !== 1'b0 || byte_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL key_timing: latency=%0d frame_err=%0b byte_valid=%0b, expected latency=1 frame_err=0 byte_valid=1",
                   cyc - stop_cyc, frame_err, byte_valid);
        end
      end
      if (byte_valid) begin
        vectors++;
        if (exp_byte.size() == 0) begin
          miscompares++;
          $display("FAIL byte_unexpected: got %02h, expected no byte", byte_out);
        end else begin
          mb = exp_byte.pop_front();
          if (byte_out !== mb) begin
            miscompares++;
            $display("FAIL byte_out: got %02h, expected %02h", byte_out, mb);
          end
        end
      end
      if (frame_err) begin
        vectors++;
        if (exp_err == 0) begin
          miscompares++;
          $display("FAIL err_unexpected: frame_err=1, expected 0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic is_stop);
    @(negedge clk); ps2_data = b;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    logic par;
    key_t k;
    par = ~(^d) ^ bad_par;
    if (!bad_par && stop) begin
      exp_byte.push_back(d);
      if (d == 8'hE0)      m_ext = 1'b1;
      else if (d == 8'hF0) m_brk = 1'b1;
      else begin
        k.code = d; k.ext = m_ext; k.brk = m_brk;
        exp_key.push_back(k);
        m_ext = 1'b0; m_brk = 1'b0;
      end
    end else begin
      exp_err++;
      m_ext = 1'b0; m_brk = 1'b0;
    end
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(stop, 1'b1);
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    vectors++;
    if ({byte_out, key_code, key_ext, key_break, key_valid, byte_valid, frame_err, busy} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_values: got %06h, expected 000000",
               {byte_out, key_code, key_ext, key_break, key_valid, byte_valid, frame_err, busy});
    end
  endtask

  task automatic test_drained(input string name);
    vectors++;
    if (exp_key.size() != 0 || exp_byte.size() != 0 || exp_err != 0) begin
      miscompares++;
      $display("FAIL %s_drained: pending keys=%0d bytes=%0d errs=%0d, expected 0 0 0",
               name, exp_key.size(), exp_byte.size(), exp_err);
    end
  endtask

  task automatic test_plain_make;
    send_frame(8'h1D, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext, key_break} !== {8'h1D, 2'b00}) begin
      miscompares++;
      $display("FAIL plain_make: got %02h/%0b/%0b, expected 1d/0/0", key_code, key_ext, key_break);
    end
    test_drained("plain_make");
  endtask

  task automatic test_ext_make_break;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext, key_break} !== {8'h75, 2'b10}) begin
      miscompares++;
      $display("FAIL ext_make: got %02h/%0b/%0b, expected 75/1/0", key_code, key_ext, key_break);
    end
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext, key_break} !== {8'h75, 2'b11}) begin
      miscompares++;
      $display("FAIL ext_break: got %02h/%0b/%0b, expected 75/1/1", key_code, key_ext, key_break);
    end
    test_drained("ext_make_break");
  endtask

  task automatic test_bad_parity;
    send_frame(8'h1D, 1'b1, 1'b1);
    vectors++;
    if (key_code !== 8'h75 || byte_out !== 8'h75) begin
      miscompares++;
      $display("FAIL bad_parity_hold: key_code=%02h byte_out=%02h, expected 75 75", key_code, byte_out);
    end
    test_drained("bad_parity");
  endtask

  task automatic test_bad_stop;
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext, key_break} !== {8'h1D, 2'b01}) begin
      miscompares++;
      $display("FAIL bad_stop_prefix: got %02h/%0b/%0b, expected 1d/0/1", key_code, key_ext, key_break);
    end
    test_drained("bad_stop");
  endtask

  task automatic test_timeout;
    int n;
    exp_err++;
    m_ext = 1'b0; m_brk = 1'b0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_busy_mid: got %0b, expected 1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 2 * T) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0 || n < T - 10 || n > T + 5) begin
      miscompares++;
      $display("FAIL timeout_release: busy=%0b after %0d cycles, expected busy=0 after %0d..%0d",
               busy, n, T - 10, T + 5);
    end
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    vectors++;
    if (key_code !== 8'h1C) begin
      miscompares++;
      $display("FAIL timeout_recover: got %02h, expected 1c", key_code);
    end
    test_drained("timeout");
  endtask

  task automatic test_idle_noise;
    send_bit(1'b1, 1'b0);
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_noise_busy: got %0b, expected 0", busy);
    end
    test_drained("idle_noise");
  endtask

  task automatic test_back_to_back;
    send_frame(8'h1B, 1'b0, 1'b1);
    send_frame(8'h23, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext, key_break} !== {8'h23, 2'b00}) begin
      miscompares++;
      $display("FAIL back_to_back: got %02h/%0b/%0b, expected 23/0/0", key_code, key_ext, key_break);
    end
    test_drained("back_to_back");
  endtask

  task automatic test_reset_mid_frame;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({byte_out, key_code, key_ext, key_break, key_valid, byte_valid, frame_err, busy} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_mid_values: got %06h, expected 000000",
               {byte_out, key_code, key_ext, key_break, key_valid, byte_valid, frame_err, busy});
    end
    rst = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1);
    vectors++;
    if ({key_code, key_ext} !== {8'h29, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_next: got %02h/%0b, expected 29/0", key_code, key_ext);
    end
    test_drained("reset_mid_frame");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_plain_make;
    test_ext_make_break;
    test_bad_parity;
    test_bad_stop;
    test_timeout;
    test_idle_noise;
    test_back_to_back;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
